// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the combinational
// instruction memory and buffers {pc, inst} pairs for decode.
module ifetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 2,
   parameter int          MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        halted,
   output logic        fault
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {RUN, HALT, FAULT} state_e;

   state_e          state_q;
   logic            halted_q;
   logic            fault_q;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [31:0]     buf_pc_q   [DEPTH];
   logic [31:0]     buf_inst_q [DEPTH];

   logic pop;
   logic push_ok;
   logic pc_bad;
   logic redirect;
   logic push;
   logic flush;

   always_comb begin
      pop      = (count_q != '0) & if_ready;
      push_ok  = (count_q < CW'(DEPTH)) | pop;
      pc_bad   = (fetch_pc_q[1:0] != 2'b00) | (fetch_pc_q[31:2] >= 30'(MEM_WORDS));
      // A faulted fetcher ignores redirects; only reset brings it back.
      redirect = redirect_valid & (state_q != FAULT);
      push     = (state_q == RUN) & ~redirect & ~pc_bad & (imem_inst != 32'h0) & push_ok;
      flush    = redirect | ((state_q == RUN) & pc_bad);
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      fetch_pc_d = fetch_pc_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
      count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
      rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
      wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= RUN;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else if (redirect) begin
         state_q  <= RUN;
         halted_q <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (pc_bad) begin
                  state_q <= FAULT;
                  fault_q <= 1'b1;
               end else if (imem_inst == 32'h0) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
               end
            end
            HALT:    state_q <= HALT;
            FAULT:   state_q <= FAULT;
            default: state_q <= FAULT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // NOTE: buffer storage is not reset; count_q qualifies every entry and the outputs are gated.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
         buf_inst_q[wr_ptr_q] <= imem_inst;
      end
   end

   assign imem_pc  = fetch_pc_q;
   assign if_valid = (count_q != '0);
   assign if_pc    = if_valid ? buf_pc_q[rd_ptr_q]   : 32'h0;
   assign if_inst  = if_valid ? buf_inst_q[rd_ptr_q] : 32'h0;
   assign halted   = halted_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the fetch buffer.
module tb_ifetch_ctrl;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          DEPTH     = 2;
   localparam int          MEM_WORDS = 256;

   logic        clk;
   logic        reset;
   logic [31:0] imem_pc;
   logic [31:0] imem_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        halted;
   logic        fault;

   logic [31:0] mem [0:MEM_WORDS-1];

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   typedef enum int {M_RUN, M_HALT, M_FAULT} mmode_e;

   ent_t        mq[$];
   logic [31:0] m_pc;
   mmode_e      m_mode;

   ifetch_ctrl #(
      .RESET_PC  (RESET_PC),
      .DEPTH     (DEPTH),
      .MEM_WORDS (MEM_WORDS)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_pc        (imem_pc),
      .imem_inst      (imem_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
      .halted         (halted),
      .fault          (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_inst = (imem_pc[31:10] == 22'd0) ? mem[imem_pc[9:2]] : 32'hFFFF_FFFF;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = RESET_PC;
      m_mode = M_RUN;
   endtask

   // One clock of the fetch rules, applied to the model's queue.
   task automatic model_step(input bit ready, input bit rv, input logic [31:0] rpc);
      bit          do_pop;
      logic [31:0] w;
      do_pop = (mq.size() != 0) && ready;
      if (m_mode == M_FAULT) return;
      if (rv) begin
         mq.delete();
         m_pc   = rpc;
         m_mode = M_RUN;
         return;
      end
      if (do_pop) void'(mq.pop_front());
      if (m_mode == M_RUN) begin
         if ((m_pc % 4) != 0 || (m_pc / 4) >= MEM_WORDS) begin
            m_mode = M_FAULT;
            mq.delete();
         end else begin
            w = mem[m_pc / 4];
            if (w == 32'h0) begin
               m_mode = M_HALT;
            end else if (mq.size() < DEPTH) begin
               mq.push_back({m_pc, w});
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   task automatic check_outputs();
      bit exp_valid;
      exp_valid = (mq.size() != 0);
      check("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
         check("if_pc",   if_pc,   mq[0].pc);
         check("if_inst", if_inst, mq[0].inst);
      end
      check("halted",  {31'b0, halted}, {31'b0, m_mode == M_HALT});
      check("fault",   {31'b0, fault},  {31'b0, m_mode == M_FAULT});
      check("imem_pc", imem_pc, m_pc);
   endtask

   // Compare, apply inputs for the coming edge, advance the model, wait one clock.
   task automatic cycle(input bit ready, input bit rv, input logic [31:0] rpc);
      check_outputs();
      if_ready       = ready;
      redirect_valid = rv;
      redirect_pc    = rpc;
      model_step(ready, rv, rpc);
      @(negedge clk);
   endtask

   // Reset asserted between edges; outputs must clear before any clock edge.
   task automatic async_reset();
      #2;
      reset          = 1'b1;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      #1;
      check("rst_if_valid", {31'b0, if_valid}, 32'd0);
      check("rst_halted",   {31'b0, halted},   32'd0);
      check("rst_fault",    {31'b0, fault},    32'd0);
      check("rst_imem_pc",  imem_pc,           RESET_PC);
      check("rst_if_pc",    if_pc,             32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset          = 1'b1;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
      mem[0] = 32'h002081B3;
      mem[1] = 32'h404182B3;
      mem[2] = 32'h00532023;
      mem[3] = 32'h00032383;
      model_reset();
      repeat (2) @(negedge clk);
      check("por_if_valid", {31'b0, if_valid}, 32'd0);
      check("por_if_inst",  if_inst, 32'd0);
      reset = 1'b0;

      // Straight-line program, then halt on the zero word at 16.
      repeat (7) cycle(1'b1, 1'b0, 32'h0);
      check("halt_pc_hold", imem_pc, 32'd16);

      // Redirect out of HALT back to 4.
      cycle(1'b1, 1'b1, 32'd4);
      repeat (6) cycle(1'b1, 1'b0, 32'h0);

      // Backpressure: buffer saturates at DEPTH, then drains in order.
      async_reset();
      repeat (5) cycle(1'b0, 1'b0, 32'h0);
      repeat (7) cycle(1'b1, 1'b0, 32'h0);

      // Redirect with a full buffer, pop completing in the redirect cycle.
      async_reset();
      repeat (3) cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 32'd12);
      repeat (4) cycle(1'b1, 1'b0, 32'h0);

      // Redirect with a full buffer and no pop.
      async_reset();
      repeat (3) cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 32'd12);
      repeat (3) cycle(1'b0, 1'b0, 32'h0);
      repeat (3) cycle(1'b1, 1'b0, 32'h0);

      // Misaligned target faults; later redirect is ignored.
      cycle(1'b1, 1'b1, 32'h6);
      repeat (2) cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 32'h0);
      repeat (2) cycle(1'b1, 1'b0, 32'h0);

      // Out-of-range target faults; async reset clears it mid-stream.
      async_reset();
      repeat (3) cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 32'(4 * MEM_WORDS));
      repeat (2) cycle(1'b1, 1'b0, 32'h0);
      async_reset();
      repeat (3) cycle(1'b1, 1'b0, 32'h0);
      async_reset();
      repeat (4) cycle(1'b1, 1'b0, 32'h0);

      // Random program and traffic.
      for (int i = 0; i < MEM_WORDS; i++) begin
         logic [31:0] w;
         w = $urandom;
         if ($urandom_range(0, 15) == 0 || w == 32'h0) w = (w == 32'h0) ? 32'h13 : 32'h0;
         mem[i] = w;
      end
      async_reset();
      for (int n = 0; n < 3000; n++) begin
         bit          rdy;
         bit          rv;
         logic [31:0] rpc;
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 19) == 0);
         rpc = {22'd0, 8'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
         if ($urandom_range(0, 7) == 0) rpc = $urandom;
         if ((m_mode == M_FAULT && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0) begin
            async_reset();
         end else begin
            cycle(rdy, rv, rpc);
         end
      end
      check_outputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch sequencer in front of the combinational instruction memory (32-bit × 256 words, word-indexed by pc[31:2]). It owns the fetch PC, drives the memory address, and buffers fetched {pc, inst} pairs in a small FIFO. Decode drains the FIFO through a valid/ready handshake. The block handles redirects (branch/jump), halts on the all-zero filler word, and traps bad fetch addresses.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- DEPTH, 2, fetch-buffer entries (power of two, ≥2)
- MEM_WORDS, 256, instruction memory rows; word index ≥ MEM_WORDS is out of range
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- imem_pc  output  32  address to instruction memory = fetch_pc register
- imem_inst  input  32  combinational read data for imem_pc (same cycle)
- redirect_valid  input  1  load redirect_pc as new fetch PC, flush buffer
- redirect_pc  input  32  redirect target
- if_valid  output  1  buffer head valid (count != 0)
- if_ready  input  1  decode accepts head this cycle
- if_pc  output  32  PC of head entry
- if_inst  output  32  instruction of head entry
- halted  output  1  fetch stopped on all-zero word
- fault  output  1  fetch stopped on misaligned or out-of-range PC; sticky until reset

## Operation
- State machine: RUN, HALT, FAULT. Reset → RUN, fetch_pc=RESET_PC, count=0, halted=0, fault=0, if_valid=0, if_pc=0, if_inst=0.
- pop = if_valid & if_ready. push_ok = (count<DEPTH) | pop.
- RUN, no redirect:
  - fetch_pc[1:0]!=0 or fetch_pc[31:2]≥MEM_WORDS → FAULT. No push.
  - imem_inst==32'h0 → HALT. No push. fetch_pc holds.
  - else if push_ok → push {fetch_pc, imem_inst}; fetch_pc += 4 (32-bit wrap, then range check applies).
  - else (full, no pop) → hold fetch_pc. Memory is re-read next cycle.
- HALT: no fetch. Buffered entries still drain. halted=1.
- FAULT: buffer flushed on entry. if_valid=0. fault=1. Redirects are ignored. Only reset exits.
- Redirect (RUN or HALT): flush buffer (count=0). fetch_pc=redirect_pc. State→RUN. halted=0. No push that cycle.
  - Target alignment/range is checked on the following cycle, as a normal fetch.
- Redirect has priority over push. A pop in the same cycle as a redirect completes: decode owns that entry. The rest of the buffer is discarded.
- Buffer is in-order. Entries are never reordered or duplicated. Simultaneous push+pop when full is legal, and count stays unchanged.

## Timing
- imem_pc is a register output. Memory read and push happen in the same cycle.
- Reset release: first fetch in cycle 0. if_valid=1 with if_pc=RESET_PC from cycle 1.
- Throughput: 1 instruction/cycle with if_ready held high. Steady-state count ≤1.
- Redirect sampled at edge N: fetch of redirect_pc during cycle N. if_valid with if_pc=redirect_pc from edge N+1. That gives exactly one bubble cycle.
- halted/fault assert the cycle after the offending fetch cycle (registered).
- if_pc/if_inst are stable while if_valid=1 and if_ready=0.
- Asynchronous reset mid-operation: all outputs go to reset values without waiting for a clock edge. Buffer contents are lost.

## Test plan
- Program add/sub/sw/lw at rows 0-3, zeros after. reset pulse, if_ready=1 → if_pc 0,4,8,12 with if_inst 0x002081B3, 0x404182B3, 0x00532023, 0x00032383 on consecutive cycles. Then halted=1 and if_valid=0. imem_pc holds 16.
- Backpressure: if_ready=0 for 5 cycles after reset → count saturates at 2 (pc 0,4) and imem_pc holds 8. Then if_ready=1 → 0,4,8,12 delivered with no loss or duplicate.
- Redirect while buffer holds pc 0,4: redirect_valid=1, redirect_pc=12 → one bubble. Next if_pc=12. Entries 0,4 are never presented (except a pop completed in the redirect cycle).
- From HALT (pc 16): redirect to 4 → halted drops next cycle. if_pc 4,8,12 delivered, then halted again.
- redirect_pc=0x6 → fault=1, if_valid=0 the cycle after. A later redirect to 0 is ignored. Only reset clears fault.
- redirect_pc=4*MEM_WORDS (0x400) → fault=1. Assert reset asynchronously mid-stream (between edges) → fault, halted, if_valid drop immediately. Restart fetches from RESET_PC.
